// File: rtl/conv1_window_buffer.sv
// rtl/conv1_window_buffer.sv - 3x3 sliding-window builder over a raster pixel stream using two line buffers
module conv1_window_buffer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pixel_in,
    output logic [DATA_W-1:0] data_out [0:8],
    output logic              valid_out,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] lb0 [0:IMG_W-1];
    logic [DATA_W-1:0] lb1 [0:IMG_W-1];
    logic              last_col;
    logic              last_row;

    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers are plain RAM: never cleared, rows 0/1 are simply never flagged valid.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                data_out[i] <= '0;
            end
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= valid_in && (row >= RW'(2)) && (col >= CW'(2));
            frame_done <= valid_in && last_row && last_col;
            if (valid_in) begin
                for (int i = 0; i < 3; i++) begin
                    data_out[3*i]   <= data_out[3*i+1];
                    data_out[3*i+1] <= data_out[3*i+2];
                end
                data_out[2] <= lb1[col];
                data_out[5] <= lb0[col];
                data_out[8] <= pixel_in;
            end
        end
    end

endmodule

// File: tb/tb_conv1_window_buffer.sv
// tb/tb_conv1_window_buffer.sv - randomized self-checking bench for conv1_window_buffer
module tb_conv1_window_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] pixel_in;
    logic [31:0] data_out [0:8];
    logic        valid_out;
    logic        frame_done;

    logic        v2;
    logic [31:0] p2;
    logic [31:0] dout2 [0:8];
    logic        vo2;
    logic        fd2;

    always #5 clk = ~clk;

    conv1_window_buffer #(.IMG_W(28), .IMG_H(28), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pixel_in(pixel_in),
        .data_out(data_out), .valid_out(valid_out), .frame_done(frame_done)
    );

    conv1_window_buffer #(.IMG_W(4), .IMG_H(3), .DATA_W(32)) dut_small (
        .clk(clk), .rst_n(rst_n), .valid_in(v2), .pixel_in(p2),
        .data_out(dout2), .valid_out(vo2), .frame_done(fd2)
    );

    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    int          nvalid;
    int          nfd;
    logic        have_first;
    logic [31:0] img [0:27][0:27];
    logic [31:0] first_win [0:8];
    logic [31:0] small_w0 [0:8] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [31:0] small_w1 [0:8] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: frame image indexed by (row, col) of the accepted beat; a window is the 3x3 block ending there.
    task automatic beat(input logic v, input logic [31:0] w);
        int r;
        int c;
        logic ev;
        logic ef;
        r = k / 28;
        c = k % 28;
        ev = 1'b0;
        ef = 1'b0;
        valid_in = v;
        pixel_in = w;
        if (v) begin
            img[r][c] = w;
            ev = (r >= 2) && (c >= 2);
            ef = (k == 28*28 - 1);
            k = (k + 1) % (28*28);
        end
        @(posedge clk);
        #1;
        chk("valid_out", {31'b0, valid_out}, {31'b0, ev});
        chk("frame_done", {31'b0, frame_done}, {31'b0, ef});
        if (frame_done) nfd++;
        if (ev) begin
            nvalid++;
            if (!have_first) begin
                for (int i = 0; i < 9; i++) first_win[i] = data_out[i];
                have_first = 1'b1;
            end
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    chk("window", data_out[3*i+j], img[r-2+i][c-2+j]);
        end
    endtask

    // mode 0: words base+idx back-to-back; mode 1: same words with random idles; mode 2: random words
    task automatic frame(input int mode, input int base);
        nvalid = 0;
        nfd = 0;
        have_first = 1'b0;
        for (int idx = 0; idx < 28*28; idx++) begin
            if (mode == 1) begin
                int idles;
                idles = $urandom_range(0, 2);
                for (int n = 0; n < idles; n++) beat(1'b0, $urandom);
            end
            beat(1'b1, (mode == 2) ? $urandom : 32'(base + idx));
        end
        chk("window_count", 32'(nvalid), 32'd676);
        chk("frame_done_count", 32'(nfd), 32'd1);
    endtask

    task automatic chk_first(input int base);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                chk("first_window", first_win[3*i+j], 32'(base + 28*i + j));
    endtask

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0;
        pixel_in = '0;
        v2 = 1'b0;
        p2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid_out", {31'b0, valid_out}, 32'd0);
        chk("reset_frame_done", {31'b0, frame_done}, 32'd0);
        for (int i = 0; i < 9; i++) chk("reset_data_out", data_out[i], 32'd0);
        rst_n = 1'b1;

        frame(0, 0);
        chk_first(0);
        frame(0, 1000);
        chk_first(1000);
        frame(1, 0);
        chk_first(0);
        frame(2, 0);

        for (int idx = 0; idx <= 300; idx++) beat(1'b1, 32'(idx));
        rst_n = 1'b0;
        valid_in = 1'b1;
        pixel_in = 32'hdead_beef;
        @(posedge clk);
        #1;
        chk("midreset_valid_out", {31'b0, valid_out}, 32'd0);
        chk("midreset_frame_done", {31'b0, frame_done}, 32'd0);
        for (int i = 0; i < 9; i++) chk("midreset_data_out", data_out[i], 32'd0);
        rst_n = 1'b1;
        k = 0;
        frame(0, 0);
        chk_first(0);
        valid_in = 1'b0;

        for (int idx = 0; idx < 12; idx++) begin
            v2 = 1'b1;
            p2 = 32'(idx);
            @(posedge clk);
            #1;
            chk("small_valid_out", {31'b0, vo2}, {31'b0, (idx >= 10)});
            chk("small_frame_done", {31'b0, fd2}, {31'b0, (idx == 11)});
            if (idx == 10) for (int i = 0; i < 9; i++) chk("small_window0", dout2[i], small_w0[i]);
            if (idx == 11) for (int i = 0; i < 9; i++) chk("small_window1", dout2[i], small_w1[i]);
        end
        v2 = 1'b0;
        @(posedge clk);
        #1;
        chk("small_idle_valid", {31'b0, vo2}, 32'd0);
        chk("small_idle_done", {31'b0, fd2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
